// File: rtl/uart_clk_arbiter.sv
// -----------------------------------------------------------------------------
// uart_clk_arbiter
//
// Shares one UART clock generator between a transmitter and a receiver.
// Each side requests the generator with its own rate setting {freq, div[2:0]}.
// The arbiter picks an owner, loads that setting into the generator while it
// is held disabled for GUARD_CYCLES clocks (so the divider chain restarts
// cleanly), then enables the generator and grants the owner. A second side
// asking for the identical setting joins the running clock without a restart.
// The generator's rate inputs come straight from the latched setting, which
// only changes while the generator is disabled.
//
// Parameters
//   GUARD_CYCLES  clocks the generator stays disabled with the new setting
//                 applied before it is enabled (>= 1)
//
// Ports
//   clk       in   system clock, all state on rising edge
//   rst       in   asynchronous reset, active low
//   req_tx    in   TX request (level, held until done)
//   cfg_tx    in   TX rate setting {freq, div[2:0]}
//   req_rx    in   RX request (level, held until done)
//   cfg_rx    in   RX rate setting {freq, div[2:0]}
//   gnt_tx    out  TX may use the UART clock
//   gnt_rx    out  RX may use the UART clock
//   gen_en    out  generator enable
//   gen_freq  out  generator base clock select
//   gen_div   out  generator divide ratio
//   busy      out  arbiter is not idle
// -----------------------------------------------------------------------------
module uart_clk_arbiter #(
   parameter int GUARD_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_tx,
   input  logic [3:0] cfg_tx,
   input  logic       req_rx,
   input  logic [3:0] cfg_rx,
   output logic       gnt_tx,
   output logic       gnt_rx,
   output logic       gen_en,
   output logic       gen_freq,
   output logic [2:0] gen_div,
   output logic       busy
);

   localparam int               CNT_W    = $clog2(GUARD_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(GUARD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Side encoding used by owner_q / last_q.
   localparam logic SIDE_TX = 1'b0;
   localparam logic SIDE_RX = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SETUP = 2'd1,
      S_RUN   = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t           state_q,  state_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [3:0]       cfg_q,    cfg_d;
   logic             owner_q,  owner_d;
   logic             last_q,   last_d;
   logic             gnt_tx_q, gnt_tx_d;
   logic             gnt_rx_q, gnt_rx_d;
   logic             gen_en_q, gen_en_d;
   logic             busy_q,   busy_d;

   logic             tx_match;
   logic             rx_match;
   logic             owner_req;
   logic             win_rx;
   logic             any_keep;

   assign tx_match  = (cfg_tx == cfg_q);
   assign rx_match  = (cfg_rx == cfg_q);
   assign owner_req = (owner_q == SIDE_RX) ? req_rx : req_tx;

   // Tie goes to the side that did not own the clock last time.
   assign win_rx    = (req_tx && req_rx) ? (last_q == SIDE_TX) : req_rx;

   // RUN continues only while some already-granted side keeps its request.
   assign any_keep  = (gnt_tx_q && req_tx) || (gnt_rx_q && req_rx);

   // -------------------------------------------------------------------------
   // State and output registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         cfg_q    <= '0;
         owner_q  <= SIDE_TX;
         last_q   <= SIDE_RX;
         gnt_tx_q <= 1'b0;
         gnt_rx_q <= 1'b0;
         gen_en_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cfg_q    <= cfg_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         gnt_tx_q <= gnt_tx_d;
         gnt_rx_q <= gnt_rx_d;
         gen_en_q <= gen_en_d;
         busy_q   <= busy_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and next-output logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cfg_d    = cfg_q;
      owner_d  = owner_q;
      last_d   = last_q;
      gnt_tx_d = 1'b0;
      gnt_rx_d = 1'b0;
      gen_en_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (req_tx || req_rx) begin
               owner_d = win_rx ? SIDE_RX : SIDE_TX;
               cfg_d   = win_rx ? cfg_rx : cfg_tx;
               cnt_d   = CNT_LOAD;
               state_d = S_SETUP;
            end
         end

         S_SETUP: begin
            // Owner withdrawing aborts the setup; the pointer keeps its value
            // so the same tie-break applies on the next attempt.
            if (!owner_req) begin
               state_d = S_IDLE;
            end else if (cnt_q == '0) begin
               state_d  = S_RUN;
               gen_en_d = 1'b1;
               last_d   = owner_q;
               gnt_tx_d = (owner_q == SIDE_TX) || (req_tx && tx_match);
               gnt_rx_d = (owner_q == SIDE_RX) || (req_rx && rx_match);
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         S_RUN: begin
            if (!any_keep) begin
               state_d = S_DRAIN;
            end else begin
               // A granted side keeps its grant while requesting; an
               // ungranted side joins only on an exact rate match.
               gen_en_d = 1'b1;
               gnt_tx_d = req_tx && (gnt_tx_q || tx_match);
               gnt_rx_d = req_rx && (gnt_rx_q || rx_match);
            end
         end

         S_DRAIN: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   assign gnt_tx   = gnt_tx_q;
   assign gnt_rx   = gnt_rx_q;
   assign gen_en   = gen_en_q;
   assign gen_freq = cfg_q[3];
   assign gen_div  = cfg_q[2:0];
   assign busy     = busy_q;

endmodule

// File: doc/uart_clk_arbiter.md
# uart_clk_arbiter

Shares a single `uart_clk_gen` instance between a UART transmitter and receiver. Each side requests the generator with its own rate setting; the arbiter picks an owner, applies the setting while holding the generator disabled long enough for its divider chain to reset, then enables it and grants the owner. Sits between the TX/RX controllers and the clock generator's `en` / `baseClock_freq` / `divRatio` inputs. A second requester asking for the identical setting joins the running clock without a restart.

## Interface
- `GUARD_CYCLES`, 4: `clk` cycles the generator is held disabled with the new setting applied before enabling; legal range ≥1.

- `clk`  in  1  system clock; all state on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_tx`  in  1  TX requests the UART clock; level, held until done.
- `cfg_tx`  in  4  TX rate setting `{freq, div[2:0]}`.
- `req_rx`  in  1  RX request, same rules.
- `cfg_rx`  in  4  RX rate setting.
- `gnt_tx`  out  1  TX may use `clk_uart`.
- `gnt_rx`  out  1  RX may use `clk_uart`.
- `gen_en`  out  1  to generator `en`.
- `gen_freq`  out  1  to generator `baseClock_freq`.
- `gen_div`  out  3  to generator `divRatio`.
- `busy`  out  1  state ≠ IDLE.

## Operation
- States: IDLE, SETUP, RUN, DRAIN. All outputs registered.
- Reset (async, `rst`=0): state IDLE; `gnt_tx`=`gnt_rx`=0, `gen_en`=0, `gen_freq`=0, `gen_div`=0, `busy`=0; round-robin pointer `last`=RX, so TX wins the first tie.
- IDLE: `gen_en`=0. If exactly one request is high, it wins. If both are high, the side not equal to `last` wins. Latch the winner's cfg into `cfg_q`, record owner, load the guard counter with `GUARD_CYCLES-1`, go to SETUP.
- SETUP: `gen_en`=0; `gen_freq`/`gen_div` driven from `cfg_q`. Counter decrements each cycle.
  - Owner's req low during SETUP: return to IDLE with no grant; `last` is not updated.
  - Counter reaches 0: go to RUN and assert the owner's grant. Assert the other grant too if that side's req is high and its cfg == `cfg_q`. Set `last` = owner.
- RUN: `gen_en`=1 and `cfg_q` held stable.
  - A granted side whose req goes low loses its grant the next cycle.
  - An ungranted side with req high and cfg == `cfg_q` gets its grant the next cycle (join).
  - An ungranted side with a mismatched cfg waits; it wins the next IDLE arbitration through the round-robin pointer.
  - Changes on a granted side's cfg are ignored. To change rate, that side must release and re-request.
  - When no granted side still has req high, go to DRAIN. This includes both releasing in the same cycle.
- DRAIN: `gen_en`=0 and grants 0 for one cycle, then IDLE.
- No configuration change ever reaches the generator while `gen_en`=1.

## Timing
- Req sampled high in IDLE at edge t:
  - SETUP from t+1.
  - `gen_en`=0 for cycles t+1..t+G, where G=`GUARD_CYCLES`.
  - RUN, `gen_en`=1 and grant=1 at t+G+1.
  - Request-to-grant latency is G+1 cycles.
- Release: req low sampled at edge t means grant low at t+1. If that was the last grant, DRAIN at t+1, IDLE at t+2, and the earliest new SETUP is t+3.
- Join latency in RUN: 1 cycle.
- Guard counter width is `$clog2(GUARD_CYCLES+1)`. G=1 gives exactly one disabled cycle in SETUP.
- Reset asserted mid-operation clears all outputs immediately and asynchronously, not at a clock edge. After reset is released, arbitration restarts from IDLE.

## Test plan
- Single TX request, G=4, `cfg_tx`=4'b0011, request at edge 0:
  - `gen_en`=0 with `gen_freq`=0, `gen_div`=3 on cycles 1–4.
  - `gnt_tx`=1 and `gen_en`=1 at cycle 5.
  - `req_tx` dropped at cycle 20: `gnt_tx`=0 and `gen_en`=0 at 21, `busy`=0 at 22.
- Simultaneous requests with mismatched cfg (`cfg_tx`=4'b0001, `cfg_rx`=4'b1010) out of reset:
  - TX is granted first; RX waits with `gnt_rx`=0.
  - After TX releases: DRAIN, then SETUP with `gen_div`=2 and `gen_freq`=1, then `gnt_rx`=1.
- Join with matching cfg: TX in RUN with cfg 4'b0101; RX requests with 4'b0101 → `gnt_rx`=1 one cycle later, and `gen_en` never drops. TX releases → RUN continues on RX. RX releases → DRAIN.
- Owner aborts during SETUP: `req_tx` drops at cycle 2 → back to IDLE by cycle 3, no grant ever asserted, `last` unchanged.
- Rate stability: while `gen_en`=1, randomly toggle the granted side's cfg → `gen_freq`/`gen_div` do not change.
- Reset mid-RUN: drive `rst`=0 between clock edges → all grants and `gen_en` go to 0 immediately, asynchronously. After release with both reqs high → TX wins.
